// File: rtl/gpu_regfile_if.sv
// Register-file port bundle between a processor core and its gpu_regfile.
// The slave modport is the register file; master is the issuing core.
interface gpu_regfile_if #(
  parameter int unsigned AW    = 4,
  parameter int unsigned WIDTH = 16
);
  logic [AW-1:0]    readreg0;
  logic [WIDTH:0]   inputreg0;
  logic [AW-1:0]    readreg1;
  logic [WIDTH:0]   inputreg1;
  logic             rsv_en;
  logic [AW-1:0]    rsv_reg;
  logic             wr_en;
  logic [AW-1:0]    wr_reg;
  logic [WIDTH-1:0] wr_data;
  logic [AW:0]      pending_count;
  logic             err;

  modport master (
    output readreg0, readreg1, rsv_en, rsv_reg, wr_en, wr_reg, wr_data,
    input  inputreg0, inputreg1, pending_count, err
  );

  modport slave (
    input  readreg0, readreg1, rsv_en, rsv_reg, wr_en, wr_reg, wr_data,
    output inputreg0, inputreg1, pending_count, err
  );
endinterface

// File: rtl/gpu_regfile.sv
// Per-core register file with a write scoreboard: 16 x 16-bit registers, two registered
// read ports returning {pending, data}, with same-edge bypass of writes and reserves.
module gpu_regfile #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  gpu_regfile_if.slave rf_io
);

  logic [WIDTH-1:0] data_q [NREGS];
  logic [WIDTH-1:0] data_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [WIDTH:0]   rd0_q, rd0_d;
  logic [WIDTH:0]   rd1_q, rd1_d;
  logic [AW:0]      count_q, count_d;
  logic             err_q, err_d;

  logic do_wr, do_rsv, same_reg;

  // Register 0 is hardwired: it is never written or reserved, so it stays 0/0.
  assign do_wr    = rf_io.wr_en  && (rf_io.wr_reg  != '0);
  assign do_rsv   = rf_io.rsv_en && (rf_io.rsv_reg != '0);
  assign same_reg = (rf_io.wr_reg == rf_io.rsv_reg);

  always_comb begin
    data_d = data_q;
    pend_d = pend_q;
    if (do_wr) begin
      data_d[rf_io.wr_reg] = rf_io.wr_data;
      pend_d[rf_io.wr_reg] = 1'b0;
    end
    // Applied after the write so a same-register reserve leaves the flag set.
    if (do_rsv) begin
      pend_d[rf_io.rsv_reg] = 1'b1;
    end
  end

  always_comb begin
    err_d = 1'b0;
    if (do_wr && !pend_q[rf_io.wr_reg] && !(do_rsv && same_reg)) begin
      err_d = 1'b1;
    end
    if (do_rsv && pend_q[rf_io.rsv_reg] && !(do_wr && same_reg)) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      count_d = count_d + {{AW{1'b0}}, pend_d[i]};
    end
  end

  // Reads observe the post-edge state, which gives the same-edge bypass for free.
  always_comb begin
    rd0_d = {pend_d[rf_io.readreg0], data_d[rf_io.readreg0]};
    rd1_d = {pend_d[rf_io.readreg1], data_d[rf_io.readreg1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        data_q[i] <= '0;
      end
      pend_q  <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      pend_q  <= pend_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign rf_io.inputreg0     = rd0_q;
  assign rf_io.inputreg1     = rd1_q;
  assign rf_io.pending_count = count_q;
  assign rf_io.err           = err_q;

endmodule

// File: tb/tb_gpu_regfile.sv
// Self-checking bench for gpu_regfile: a behavioural scoreboard model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_gpu_regfile;

  logic clk;
  logic rst;

  gpu_regfile_if #(.AW(4), .WIDTH(16)) rf ();

  gpu_regfile #(.NREGS(16), .AW(4), .WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .rf_io (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Behavioural model state
  logic [15:0] mdata [16];
  bit          mpend [16];
  logic [16:0] exp0, exp1;
  int          expcnt;
  bit          experr;
  bit          model_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit w, r, e;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mdata[i] = 16'h0;
        mpend[i] = 1'b0;
      end
      exp0 = '0; exp1 = '0; expcnt = 0; experr = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      w = rf.wr_en  && (rf.wr_reg  != 4'd0);
      r = rf.rsv_en && (rf.rsv_reg != 4'd0);
      e = 1'b0;
      if (w && !mpend[rf.wr_reg] && !(r && rf.rsv_reg == rf.wr_reg)) e = 1'b1;
      if (r && mpend[rf.rsv_reg] && !(w && rf.wr_reg == rf.rsv_reg)) e = 1'b1;
      if (w) begin
        mdata[rf.wr_reg] = rf.wr_data;
        mpend[rf.wr_reg] = 1'b0;
      end
      if (r) mpend[rf.rsv_reg] = 1'b1;
      experr = e;
      exp0 = {mpend[rf.readreg0], mdata[rf.readreg0]};
      exp1 = {mpend[rf.readreg1], mdata[rf.readreg1]};
      expcnt = 0;
      for (int i = 0; i < 16; i++) expcnt += int'(mpend[i]);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_inputreg0", 32'(rf.inputreg0), 32'(exp0));
      check("model_inputreg1", 32'(rf.inputreg1), 32'(exp1));
      check("model_pending_count", 32'(rf.pending_count), 32'(expcnt));
      check("model_err", 32'(rf.err), 32'(experr));
    end
  end

  // Drive one cycle of requests, then land 1 time unit after the sampling edge.
  task automatic step(input logic [3:0] r0, input logic [3:0] r1,
                      input logic re, input logic [3:0] rr,
                      input logic we, input logic [3:0] wr, input logic [15:0] wd);
    rf.readreg0 = r0;
    rf.readreg1 = r1;
    rf.rsv_en   = re;
    rf.rsv_reg  = rr;
    rf.wr_en    = we;
    rf.wr_reg   = wr;
    rf.wr_data  = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    model_ok = 1'b0;
    rst      = 1'b1;
    rf.readreg0 = 4'd0; rf.readreg1 = 4'd0;
    rf.rsv_en = 1'b0; rf.rsv_reg = 4'd0;
    rf.wr_en = 1'b0; rf.wr_reg = 4'd0; rf.wr_data = 16'h0;

    step(4'd0, 4'd0, 1'b1, 4'd6, 1'b1, 4'd6, 16'hAAAA);
    step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
    check("reset_inputreg0", 32'(rf.inputreg0), 32'h0);
    check("reset_count", 32'(rf.pending_count), 32'h0);
    check("reset_err", 32'(rf.err), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(4'(i), 4'(15 - i), 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
      check("sweep_inputreg0", 32'(rf.inputreg0), 32'h0);
      check("sweep_inputreg1", 32'(rf.inputreg1), 32'h0);
    end
    check("sweep_count", 32'(rf.pending_count), 32'h0);

    // Reserve r5, then write it back with a bypassed read
    step(4'd5, 4'd0, 1'b1, 4'd5, 1'b0, 4'd0, 16'h0);
    check("rsv5_read", 32'(rf.inputreg0), 32'h10000);
    check("rsv5_count", 32'(rf.pending_count), 32'd1);
    step(4'd5, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, 16'hBEEF);
    check("wr5_bypass", 32'(rf.inputreg0), 32'h0BEEF);
    check("wr5_count", 32'(rf.pending_count), 32'd0);
    check("wr5_err", 32'(rf.err), 32'd0);

    // Same-edge write and reserve of r3: reserve wins
    step(4'd0, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 16'h1234);
    check("wr_rsv3_read", 32'(rf.inputreg1), 32'h11234);
    check("wr_rsv3_count", 32'(rf.pending_count), 32'd1);
    check("wr_rsv3_err", 32'(rf.err), 32'd0);

    // Unreserved write, then double reserve
    step(4'd7, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 16'h0042);
    check("wr7_err", 32'(rf.err), 32'd1);
    check("wr7_read", 32'(rf.inputreg0), 32'h00042);
    step(4'd7, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
    check("wr7_err_pulse", 32'(rf.err), 32'd0);
    step(4'd7, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0, 16'h0);
    check("rsv7_first_err", 32'(rf.err), 32'd0);
    step(4'd7, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0, 16'h0);
    check("rsv7_second_err", 32'(rf.err), 32'd1);
    check("rsv7_count", 32'(rf.pending_count), 32'd2);

    // Register 0 ignores writes and reserves
    step(4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 16'hFFFF);
    check("r0_read", 32'(rf.inputreg0), 32'h0);
    check("r0_err", 32'(rf.err), 32'd0);
    check("r0_count", 32'(rf.pending_count), 32'd2);

    // Different registers on the same edge: net zero count change
    step(4'd9, 4'd0, 1'b1, 4'd9, 1'b0, 4'd0, 16'h0);
    step(4'd9, 4'd10, 1'b1, 4'd10, 1'b1, 4'd9, 16'h0909);
    check("diff_read9", 32'(rf.inputreg0), 32'h00909);
    check("diff_read10", 32'(rf.inputreg1), 32'h10000);
    check("diff_count", 32'(rf.pending_count), 32'd3);
    check("diff_err", 32'(rf.err), 32'd0);

    // Reserve r1..r4 (r3 already pending), repeat r4, then reset with a write to r2
    for (int i = 1; i <= 4; i++) step(4'(i), 4'd0, 1'b1, 4'(i), 1'b0, 4'd0, 16'h0);
    step(4'd4, 4'd0, 1'b1, 4'd4, 1'b0, 4'd0, 16'h0);
    check("pre_rst_err", 32'(rf.err), 32'd1);
    check("pre_rst_count", 32'(rf.pending_count), 32'd6);
    rst = 1'b1;
    step(4'd2, 4'd3, 1'b0, 4'd0, 1'b1, 4'd2, 16'h5555);
    rst = 1'b0;
    check("rst_err", 32'(rf.err), 32'd0);
    check("rst_count", 32'(rf.pending_count), 32'd0);
    check("rst_inputreg0", 32'(rf.inputreg0), 32'h0);
    step(4'd2, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
    check("post_rst_r2", 32'(rf.inputreg0), 32'h0);
    check("post_rst_r3", 32'(rf.inputreg1), 32'h0);
    step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpu_regfile.md
# gpu_regfile

Per-core register file and write scoreboard serving the processor's two register read ports (readreg0/inputreg0, readreg1/inputreg1). It holds sixteen 16-bit general registers and returns 17-bit read words: bit 16 is the register's pending-write (scoreboard) flag and bits 15:0 are the register data. The processor reserves a destination at issue and retires it at writeback. The block sits beside each processor instance inside the gpu top level.

## Interface
Parameters:
- NREGS, 16, number of registers; must be a power of two.
- AW, 4, register index width; must equal log2(NREGS).
- WIDTH, 16, data width; read words are WIDTH+1 bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- readreg0  in  AW  read port 0 register index.
- inputreg0  out  WIDTH+1  read port 0 result: {pending, data}.
- readreg1  in  AW  read port 1 register index.
- inputreg1  out  WIDTH+1  read port 1 result: {pending, data}.
- rsv_en  in  1  reserve request; marks rsv_reg pending.
- rsv_reg  in  AW  register to reserve.
- wr_en  in  1  writeback request.
- wr_reg  in  AW  writeback destination.
- wr_data  in  WIDTH  writeback value.
- pending_count  out  AW+1  number of registers currently pending.
- err  out  1  one-cycle protocol-error pulse.

## Operation
- Storage: NREGS x WIDTH data array plus an NREGS-bit pending vector.
- Register 0:
  - Always reads data 0 with pending 0.
  - Writes to it are ignored.
  - Reserves of it are ignored.
  - Operations on it never raise err.
- Reads: both ports are independent and registered. Each samples its index every cycle and returns {pending[idx], data[idx]} as the post-edge state.
- Bypass: a read whose index matches a write or reserve committed on the same edge returns the updated data and flag.
- Reserve (rsv_en, rsv_reg != 0): sets pending[rsv_reg].
- Write (wr_en, wr_reg != 0): stores wr_data and clears pending[wr_reg].
- Simultaneous write and reserve to the same register: data is updated and pending ends at 1 (the reserve wins). This supports back-to-back producers of the same destination.
- Simultaneous write and reserve to different registers: both take effect.
- pending_count: tracks the population of the pending vector.
  - Same-edge set and clear of different registers nets to zero change.
  - Set and clear of the same register nets to no change, because pending stays 1.
  - Never exceeds NREGS-1.
- err pulses high for exactly the cycle after any of:
  - a write to a nonzero register whose pending flag was 0 before the edge, unless a same-edge reserve targets it;
  - a reserve of a nonzero register already pending, unless a same-edge write targets it.
  - On error the operation is still performed as specified above.
- No stalls and no backpressure: every request is accepted every cycle.

## Timing
- Reset values: every data word 0, every pending flag 0, inputreg0 = inputreg1 = 0, pending_count = 0, err = 0.
- Reset has priority over rsv_en and wr_en on the same edge; requests on that edge are dropped.
- Reset asserted mid-operation clears all pending state, and clears any queued err, within one edge.
- Read latency: an index presented before edge N produces its result valid after edge N and held until edge N+1.
- Write and reserve latency: effective at the edge where they are sampled. They are visible through bypass on that same edge's read result.
- pending_count and err are registered and update on the same edge as the state change that causes them.

## Test plan
- Reset, then read indices 0..15 on both ports -> every inputreg = 17'h00000; pending_count = 0; err = 0.
- Reserve r5; on the next cycle write r5 = 16'hBEEF while reading r5 on port 0 -> the read before the write shows 17'h10000. The bypassed read shows 17'h0BEEF. pending_count goes 0 -> 1 -> 0.
- Same-edge write r3 = 16'h1234 and reserve r3 -> port 1 read shows 17'h11234; pending_count = 1; err = 0.
- Write r7 = 16'h0042 with r7 not pending -> err high for one cycle; r7 reads 17'h00042. Reserve r7 twice in a row -> err on the second reserve only.
- Write r0 = 16'hFFFF and reserve r0 -> r0 reads 17'h00000; err = 0; pending_count unchanged.
- Reserve r1..r4, assert rst together with a write to r2 -> all outputs return to 0; r2 data reads 0 afterward; pending_count = 0.
